disp_scan: RTL and testbench

Time-multiplexed 4-digit seven-segment display driver that consumes the 16-bit counter word produced by the counter block and drives a common-anode display. It holds a tear-free shadow copy of the word, scans one hex digit per prescaler period, and applies anti-ghost guard blanking, per-digit decimal points and optional leading-zero blanking. It sits between the counter bank and the board display pins.

---
 rtl/disp_pkg.sv | 17 +
 rtl/disp_scan_if.sv | 14 +
 rtl/hex7seg.sv | 11 +
 rtl/disp_scan.sv | 93 +++++++++
 tb/tb_disp_scan.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/disp_pkg.sv
// Shared constants for the seven-segment scan driver: digit geometry,
// the active-low gfedcba segment table and the idle output levels.
package disp_pkg;

  localparam int DIGITS = 4;
  localparam int NIB_W  = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  // Indexed by nibble value 0..F, active-low {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/disp_scan_if.sv
// Display-side bundle: word/decimal-point/hold inputs toward the driver and
// the active-low pin outputs plus frame pulse back out.
interface disp_scan_if;
  logic [15:0] data;
  logic [3:0]  dp;
  logic        hold;
  logic [3:0]  AN;
  logic [6:0]  SEG;
  logic        DP;
  logic        frame;

  modport master (output data, dp, hold, input AN, SEG, DP, frame);
  modport slave  (input data, dp, hold, output AN, SEG, DP, frame);
endinterface

// File: rtl/hex7seg.sv
// Combinational nibble to active-low seven-segment decoder.
module hex7seg
  import disp_pkg::*;
(
  input  logic [NIB_W-1:0] nib,
  output logic [6:0]       seg
);

  assign seg = SEG_TABLE[nib];

endmodule

// File: rtl/disp_scan.sv
// Four-digit multiplexed seven-segment driver. A prescaler sets the slot
// length, the digit index walks 0..3, and the shadow word only reloads at
// the frame boundary so a frame never mixes two words.
module disp_scan
  import disp_pkg::*;
#(
  parameter int PRESCALE = 50000,
  parameter int GUARD    = 2,
  parameter int LZB      = 0
) (
  input  logic      clk,
  input  logic      clr,
  disp_scan_if.slave bus
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam int PC_W  = $clog2(PRESCALE);
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PRESCALE - 1);
  // One bit wider than pc so a GUARD equal to a power of two still fits.
  localparam logic [PC_W:0]   GUARD_V = (PC_W + 1)'(GUARD);

  logic [PC_W-1:0]  pc;
  logic [IDX_W-1:0] idx;
  logic [15:0]      sh;
  logic [3:0]       shdp;

  logic             tick;
  logic             fb;
  logic [NIB_W-1:0] nib;
  logic [6:0]       seg_dec;
  logic             upper_zero;
  logic             blank;
  logic [3:0]       an_next;
  logic [6:0]       seg_next;
  logic             dp_next;

  assign tick = (pc == PC_LAST);
  assign fb   = tick && (idx == IDX_W'(DIGITS - 1));
  assign nib  = sh[{idx, 2'b00} +: NIB_W];

  hex7seg u_dec (
    .nib (nib),
    .seg (seg_dec)
  );

  // Scan state: prescaler, digit index and the frame-aligned shadow copy.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pc   <= '0;
      idx  <= '0;
      sh   <= '0;
      shdp <= '0;
    end else begin
      pc <= tick ? '0 : pc + 1'b1;
      if (tick) idx <= idx + 1'b1;
      if (fb && !bus.hold) begin
        sh   <= bus.data;
        shdp <= bus.dp;
      end
    end
  end

  // Leading-zero detect and next values for the registered pin outputs.
  always_comb begin
    upper_zero = 1'b0;
    unique case (idx)
      2'd0:    upper_zero = 1'b0;
      2'd1:    upper_zero = (sh[15:4] == 12'h000);
      2'd2:    upper_zero = (sh[15:8] == 8'h00);
      default: upper_zero = (sh[15:12] == 4'h0);
    endcase
    blank    = (LZB != 0) && upper_zero;
    an_next  = ({1'b0, pc} < GUARD_V) ? AN_OFF : ~(4'b0001 << idx);
    seg_next = blank ? SEG_BLANK : seg_dec;
    dp_next  = blank ? 1'b1 : ~shdp[idx];
  end

  // Output registers, one cycle behind the state that produced them.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      bus.AN    <= AN_OFF;
      bus.SEG   <= SEG_BLANK;
      bus.DP    <= 1'b1;
      bus.frame <= 1'b0;
    end else begin
      bus.AN    <= an_next;
      bus.SEG   <= seg_next;
      bus.DP    <= dp_next;
      bus.frame <= fb;
    end
  end

endmodule

// File: tb/tb_disp_scan.sv
// Bench for disp_scan: two instances (LZB off/on) share one stimulus stream
// and are compared every cycle against a frame/slot arithmetic model.
module tb_disp_scan;

  localparam int P  = 4;
  localparam int G  = 1;
  localparam int FR = 4 * P;

  logic        clk = 1'b0;
  logic        clr;
  logic [15:0] data_v;
  logic [3:0]  dp_v;
  logic        hold_v;

  always #5 clk = ~clk;

  disp_scan_if b0 ();
  disp_scan_if b1 ();

  assign b0.data = data_v;
  assign b0.dp   = dp_v;
  assign b0.hold = hold_v;
  assign b1.data = data_v;
  assign b1.dp   = dp_v;
  assign b1.hold = hold_v;

  disp_scan #(.PRESCALE(P), .GUARD(G), .LZB(0)) d0 (.clk(clk), .clr(clr), .bus(b0));
  disp_scan #(.PRESCALE(P), .GUARD(G), .LZB(1)) d1 (.clk(clk), .clr(clr), .bus(b1));

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Model: k = edges since reset release; shown word/dp latched at frame ends.
  int          k;
  logic [15:0] msh;
  logic [3:0]  mshdp;
  logic [6:0]  tbl [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s at k=%0d: got %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  function automatic void expect_out(input bit lzb, output logic [3:0] an,
                                     output logic [6:0] seg, output logic dpo,
                                     output logic fr);
    int slot;
    int pcv;
    int n;
    bit blank;
    slot  = (k / P) % 4;
    pcv   = k % P;
    n     = int'((msh >> (4 * slot)) & 16'h000F);
    blank = lzb && (slot > 0) && ((msh >> (4 * slot)) == 16'h0);
    an = 4'hF;
    if (pcv >= G) an[slot] = 1'b0;
    seg = blank ? 7'h7F : tbl[n];
    dpo = blank ? 1'b1 : !mshdp[slot];
    fr  = ((k % FR) == FR - 1);
  endfunction

  task automatic step();
    logic [3:0] a0, a1;
    logic [6:0] s0, s1;
    logic       p0, p1, f0, f1;
    expect_out(1'b0, a0, s0, p0, f0);
    expect_out(1'b1, a1, s1, p1, f1);
    @(posedge clk);
    if (((k % FR) == FR - 1) && !hold_v) begin
      msh   = data_v;
      mshdp = dp_v;
    end
    k++;
    #1;
    chk("an0",    16'(b0.AN),    16'(a0));
    chk("seg0",   16'(b0.SEG),   16'(s0));
    chk("dp0",    16'(b0.DP),    16'(p0));
    chk("frame0", 16'(b0.frame), 16'(f0));
    chk("an1",    16'(b1.AN),    16'(a1));
    chk("seg1",   16'(b1.SEG),   16'(s1));
    chk("dp1",    16'(b1.DP),    16'(p1));
    chk("frame1", 16'(b1.frame), 16'(f1));
  endtask

  task automatic chk_reset_outputs();
    chk("rst_an0",  16'(b0.AN),    16'hF);
    chk("rst_seg0", 16'(b0.SEG),   16'h7F);
    chk("rst_dp0",  16'(b0.DP),    16'h1);
    chk("rst_fr0",  16'(b0.frame), 16'h0);
    chk("rst_an1",  16'(b1.AN),    16'hF);
    chk("rst_seg1", 16'(b1.SEG),   16'h7F);
  endtask

  initial begin
    clr = 1'b1; data_v = '0; dp_v = '0; hold_v = 1'b0;
    k = 0; msh = '0; mshdp = '0;
    #1;
    chk_reset_outputs();
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;

    // Decode of a mixed word.
    data_v = 16'h1A2F;
    repeat (3 * FR) step();

    // Asynchronous reset in the middle of a slot.
    repeat (5) step();
    #2 clr = 1'b1;
    #1 chk_reset_outputs();
    k = 0; msh = '0; mshdp = '0;
    @(posedge clk);
    #1 clr = 1'b0;

    // Tear-free: new word arrives while digit 1 is on screen.
    data_v = 16'h1234;
    repeat (2 * FR) step();
    while ((k % FR) != 5) step();
    data_v = 16'hABCD;
    repeat (2 * FR) step();

    // Hold across frame boundaries, then release.
    hold_v = 1'b1;
    data_v = 16'hFFFF;
    repeat (2 * FR) step();
    hold_v = 1'b0;
    repeat (2 * FR) step();

    // Leading zeros.
    data_v = 16'h0050;
    repeat (2 * FR) step();
    data_v = 16'h0000;
    repeat (2 * FR) step();

    // Decimal point on digit 2.
    data_v = 16'h8421;
    dp_v   = 4'b0100;
    repeat (2 * FR) step();

    // Random words, dp and hold toggling at arbitrary cycles.
    for (int i = 0; i < 40 * FR; i++) begin
      if ($urandom_range(0, 5) == 0)
        data_v = 16'($urandom) >> (4 * $urandom_range(0, 4));
      if ($urandom_range(0, 7) == 0) dp_v = 4'($urandom);
      hold_v = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
